vending_controller: RTL and testbench
=====================================

Name: vending_controller

Overview:
- Top-level sequencer for the vending machine datapath.
- Owns the credit balance and the inactivity (coin-return) timer, and accepts coin inserts and item purchases.
- On a return trigger or timeout, dispenses change one coin at a time to the coin dispenser over a valid/ready handshake, greedy largest-first.
- Sits between the front-panel inputs and the item/coin dispensers.

Parameters:
- WAIT_CYCLES, 10, timer reload value after any accepted coin or successful purchase.
- BAL_W, 16, balance register width in units of won (max balance 65535; a coin that would overflow it is rejected).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- i_input_coin  input  kNumCoins  one-hot coin insert pulse; bit0=100, bit1=500, bit2=1000.
- i_select_item  input  kNumItems  one-hot item request pulse; prices 400, 500, 1000, 2000.
- i_trigger_return  input  1  user return request pulse.
- i_disp_ready  input  1  coin dispenser ready.
- o_return_coin  output  kNumCoins  one-hot coin being dispensed; valid only with o_return_valid.
- o_return_valid  output  1  coin dispense request.
- o_output_item  output  kNumItems  one-cycle one-hot item dispense pulse.
- o_current_total  output  BAL_W  current balance.
- o_wait_time  output  32  remaining timer cycles.
- o_busy  output  1  high in RETURN; coin slot closed.

Behaviour:
- Reset (reset_n low at posedge) dominates everything and may occur mid-RETURN:
  - state = IDLE; balance, wait_time, o_return_coin, o_return_valid, o_output_item and o_busy all 0.
  - A pending dispense is dropped.
- All outputs are registered.
- FSM states: IDLE (balance 0), ACTIVE (balance > 0), RETURN.
- Coin insert, in IDLE/ACTIVE only:
  - Accepted when i_input_coin is exactly one-hot.
  - Effect at the next edge: balance += value; wait_time = WAIT_CYCLES; state = ACTIVE.
  - Zero, multi-hot, or overflowing inputs are ignored with no timer reload.
- Purchase, in ACTIVE only:
  - Accepted when i_select_item is one-hot and balance (pre-edge value) >= price.
  - Effect at the next edge: o_output_item = that bit for exactly one cycle; balance -= price; wait_time reloads.
  - Insufficient funds or a non-one-hot request: no dispense, no reload, no balance change.
- Coin and purchase in the same cycle:
  - Price is checked against the pre-edge balance.
  - balance_next = balance + coin − price.
  - The timer reloads once.
- Timer, in ACTIVE: decrements by 1 per edge while > 0 and saturates at 0.
  - Enter RETURN at the edge where wait_time == 0 and balance > 0.
  - Example: coin accepted at edge E0 gives wait_time 10 after E0 and 0 after E10; state is RETURN after E11.
- Entering RETURN via trigger:
  - i_trigger_return in ACTIVE goes to RETURN at the next edge; it wins over a same-cycle coin or purchase, which are ignored.
  - A trigger in IDLE or RETURN is ignored.
- Inside RETURN:
  - o_busy = 1; o_wait_time = 0; coin, select and trigger inputs are ignored.
  - o_return_valid = 1; o_return_coin = largest coin value <= balance (1000, then 500, then 100).
  - o_return_coin and o_return_valid are registered and valid from the first cycle of RETURN.
- Handshake:
  - Transfer happens at an edge with valid && ready; balance -= coin value, and the next coin is presented in the following cycle.
  - valid and coin stay stable while ready is low (no retraction).
  - When the transfer zeroes the balance: state = IDLE, valid and coin go to 0 at that edge.
  - Back-to-back transfers under continuous ready give one coin per cycle.
- Balance is always a multiple of 100, so the greedy choice always terminates at 0.

Decomposition:
- Shared package (extend vending_machine_def.v):
  - kNumCoins, kNumItems.
  - Coin value constants 100/500/1000 and item price constants 400/500/1000/2000.
  - FSM state encodings IDLE/ACTIVE/RETURN.
- One natural sub-module, return_timer:
  - Reload/decrement/saturate counter with synchronous active-low reset.
  - Inputs: reload, enable. Outputs: wait_time, expired.

Test Plan:
- Insert 1000, 500, 100 on consecutive cycles, trigger, ready held 1 → o_current_total = 1600; coins 100b, 010b, 001b on three consecutive cycles; IDLE after the third.
- Insert 500 and 100, no further input → wait_time counts 10..0; RETURN entered 11 edges after the last coin; coins 010b then 001b.
- Balance 400, select item1 (500) → no o_output_item, balance stays 400, timer not reloaded; then select item0 (400) → o_output_item = 0001 for one cycle, balance 0, state IDLE.
- RETURN with balance 1500, ready low for 3 cycles then high → o_return_coin = 100b stable and valid for 4 cycles, then 010b, then IDLE.
- Same-cycle 1000 coin + item2 (1000) with balance 500 → no dispense, balance 1500; repeat with balance 1000 → item pulse, balance 1000.
- reset_n low during RETURN mid-dispense → next cycle all outputs 0 and state IDLE; a coin inserted afterward is credited normally.

Source files
------------

// File: rtl/vending_controller_pkg.sv
// Shared definitions for the vending machine controller.
//   - Coin and item counts, coin values and item prices (in won).
//   - FSM state encoding.
//   - Helpers: one-hot coin -> value, one-hot item -> price,
//     and the greedy largest-first change coin for a given balance.
package vending_controller_pkg;

  localparam int kNumCoins = 3;
  localparam int kNumItems = 4;

  // Coin values: bit0, bit1, bit2 of the coin vectors.
  localparam int unsigned kCoin0Value = 100;
  localparam int unsigned kCoin1Value = 500;
  localparam int unsigned kCoin2Value = 1000;

  // Item prices: bit0 .. bit3 of the item vectors.
  localparam int unsigned kItem0Price = 400;
  localparam int unsigned kItem1Price = 500;
  localparam int unsigned kItem2Price = 1000;
  localparam int unsigned kItem3Price = 2000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // balance is zero
    ST_ACTIVE = 2'd1,  // balance is non-zero, accepting coins and purchases
    ST_RETURN = 2'd2   // paying out change, coin slot closed
  } state_e;

  // Value of a one-hot coin vector; anything not exactly one-hot is 0.
  function automatic int unsigned coin_value(input logic [kNumCoins-1:0] coin);
    int unsigned val;
    case (coin)
      3'b001:  val = kCoin0Value;
      3'b010:  val = kCoin1Value;
      3'b100:  val = kCoin2Value;
      default: val = 0;
    endcase
    return val;
  endfunction

  // Price of a one-hot item vector; anything not exactly one-hot is 0.
  function automatic int unsigned item_price(input logic [kNumItems-1:0] item);
    int unsigned val;
    case (item)
      4'b0001: val = kItem0Price;
      4'b0010: val = kItem1Price;
      4'b0100: val = kItem2Price;
      4'b1000: val = kItem3Price;
      default: val = 0;
    endcase
    return val;
  endfunction

  // Largest coin not exceeding the balance; zero when nothing fits.
  function automatic logic [kNumCoins-1:0] greedy_coin(input int unsigned bal);
    logic [kNumCoins-1:0] coin;
    if (bal >= kCoin2Value)      coin = 3'b100;
    else if (bal >= kCoin1Value) coin = 3'b010;
    else if (bal >= kCoin0Value) coin = 3'b001;
    else                         coin = 3'b000;
    return coin;
  endfunction

endpackage

// File: rtl/vending_controller_timer.sv
// Inactivity (coin-return) timer.
//   clk         : system clock
//   reset_n     : synchronous active-low reset, clears the count
//   clear_i     : force the count to 0 (used while paying out change)
//   reload_i    : load WAIT_CYCLES
//   enable_i    : count down by one per edge, saturating at 0
//   wait_time_o : remaining cycles (registered)
//   expired_o   : count is 0
module return_timer #(
  parameter int WAIT_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_i,
  input  logic        reload_i,
  input  logic        enable_i,
  output logic [31:0] wait_time_o,
  output logic        expired_o
);

  logic [31:0] wait_q, wait_d;

  always_comb begin
    wait_d = wait_q;
    if (clear_i)                       wait_d = '0;
    else if (reload_i)                 wait_d = 32'(WAIT_CYCLES);
    else if (enable_i && wait_q != 0)  wait_d = wait_q - 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) wait_q <= '0;
    else          wait_q <= wait_d;
  end

  assign wait_time_o = wait_q;
  assign expired_o   = (wait_q == '0);

endmodule

// File: rtl/vending_controller.sv
// Vending machine top-level sequencer.
// Owns the credit balance and inactivity timer, accepts coins and purchases,
// and pays change back one coin at a time, largest first, over valid/ready.
//   clk              : system clock
//   reset_n          : synchronous active-low reset
//   i_input_coin     : one-hot coin insert pulse (100 / 500 / 1000)
//   i_select_item    : one-hot item request pulse (400 / 500 / 1000 / 2000)
//   i_trigger_return : user change-return request
//   i_disp_ready     : coin dispenser ready
//   o_return_coin    : one-hot coin being paid out, qualified by o_return_valid
//   o_return_valid   : coin dispense request
//   o_output_item    : one-cycle one-hot item dispense pulse
//   o_current_total  : current balance
//   o_wait_time      : remaining inactivity cycles
//   o_busy           : paying out change, coin slot closed
module vending_controller
  import vending_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = 10,
  parameter int BAL_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [kNumCoins-1:0] i_input_coin,
  input  logic [kNumItems-1:0] i_select_item,
  input  logic                 i_trigger_return,
  input  logic                 i_disp_ready,
  output logic [kNumCoins-1:0] o_return_coin,
  output logic                 o_return_valid,
  output logic [kNumItems-1:0] o_output_item,
  output logic [BAL_W-1:0]     o_current_total,
  output logic [31:0]          o_wait_time,
  output logic                 o_busy
);

  state_e               state_q, state_d;
  logic [BAL_W-1:0]     bal_q, bal_d;
  logic [kNumCoins-1:0] rcoin_q, rcoin_d;
  logic                 rvalid_q, rvalid_d;
  logic [kNumItems-1:0] item_q, item_d;
  logic                 busy_q, busy_d;

  logic        tmr_clear, tmr_reload, tmr_en, tmr_expired;
  logic [31:0] tmr_wait;

  // Input decode.
  logic [BAL_W-1:0] coin_val, price, active_bal, xfer_bal;
  logic [BAL_W:0]   coin_sum;
  logic             coin_ok, buy_ok, go_return, xfer;

  always_comb begin
    coin_val = BAL_W'(coin_value(i_input_coin));
    price    = BAL_W'(item_price(i_select_item));
    // One extra bit so a coin that would wrap the balance can be rejected.
    coin_sum = {1'b0, bal_q} + {1'b0, coin_val};
    coin_ok  = $onehot(i_input_coin) && !coin_sum[BAL_W];
    // Price is checked against the balance before any same-cycle coin.
    buy_ok   = (state_q == ST_ACTIVE) && $onehot(i_select_item) && (bal_q >= price);
    // Trigger or timeout wins over any same-cycle coin or purchase.
    go_return = (state_q == ST_ACTIVE) && (i_trigger_return || tmr_expired);
    xfer      = (state_q == ST_RETURN) && rvalid_q && i_disp_ready;
    active_bal = (coin_ok ? coin_sum[BAL_W-1:0] : bal_q) - (buy_ok ? price : '0);
    xfer_bal   = bal_q - BAL_W'(coin_value(rcoin_q));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (coin_ok) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (go_return)            state_d = ST_RETURN;
        else if (active_bal == 0) state_d = ST_IDLE;
      end
      ST_RETURN: begin
        if (xfer && xfer_bal == 0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    bal_d      = bal_q;
    rcoin_d    = rcoin_q;
    rvalid_d   = rvalid_q;
    item_d     = '0;
    busy_d     = (state_d == ST_RETURN);
    tmr_clear  = 1'b0;
    tmr_reload = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (coin_ok) begin
          bal_d      = coin_sum[BAL_W-1:0];
          tmr_reload = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (go_return) begin
          // First change coin is presented in the very first RETURN cycle.
          tmr_clear = 1'b1;
          rvalid_d  = 1'b1;
          rcoin_d   = greedy_coin(32'(bal_q));
        end else begin
          bal_d      = active_bal;
          item_d     = buy_ok ? i_select_item : '0;
          tmr_reload = coin_ok || buy_ok;
        end
      end
      ST_RETURN: begin
        tmr_clear = 1'b1;
        if (xfer) begin
          bal_d = xfer_bal;
          if (xfer_bal == 0) begin
            rvalid_d = 1'b0;
            rcoin_d  = '0;
          end else begin
            rcoin_d = greedy_coin(32'(xfer_bal));
          end
        end
      end
      default: begin
        bal_d    = '0;
        rvalid_d = 1'b0;
        rcoin_d  = '0;
      end
    endcase
  end

  assign tmr_en = (state_q == ST_ACTIVE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bal_q    <= '0;
      rcoin_q  <= '0;
      rvalid_q <= 1'b0;
      item_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      bal_q    <= bal_d;
      rcoin_q  <= rcoin_d;
      rvalid_q <= rvalid_d;
      item_q   <= item_d;
      busy_q   <= busy_d;
    end
  end

  return_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_i    (tmr_clear),
    .reload_i   (tmr_reload),
    .enable_i   (tmr_en),
    .wait_time_o(tmr_wait),
    .expired_o  (tmr_expired)
  );

  assign o_return_coin   = rcoin_q;
  assign o_return_valid  = rvalid_q;
  assign o_output_item   = item_q;
  assign o_current_total = bal_q;
  assign o_wait_time     = tmr_wait;
  assign o_busy          = busy_q;

endmodule

// File: tb/tb_vending_controller.sv
module tb_vending_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  i_input_coin;
  logic [3:0]  i_select_item;
  logic        i_trigger_return;
  logic        i_disp_ready;
  logic [2:0]  o_return_coin;
  logic        o_return_valid;
  logic [3:0]  o_output_item;
  logic [15:0] o_current_total;
  logic [31:0] o_wait_time;
  logic        o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  vending_controller #(.WAIT_CYCLES(10), .BAL_W(16)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_input_coin    (i_input_coin),
    .i_select_item   (i_select_item),
    .i_trigger_return(i_trigger_return),
    .i_disp_ready    (i_disp_ready),
    .o_return_coin   (o_return_coin),
    .o_return_valid  (o_return_valid),
    .o_output_item   (o_output_item),
    .o_current_total (o_current_total),
    .o_wait_time     (o_wait_time),
    .o_busy          (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  coin;
    logic [3:0]  item;
    logic        trig;
    logic        rdy;
    logic [15:0] total;
    logic [31:0] wt;
    logic        vld;
    logic [2:0]  rc;
    logic [3:0]  oi;
    logic        busy;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] total, input logic [31:0] wt,
                            input logic vld, input logic [2:0] rc, input logic [3:0] oi,
                            input logic busy);
    chk({tag, ".total"}, 32'(o_current_total), 32'(total));
    chk({tag, ".wait"},  o_wait_time, wt);
    chk({tag, ".valid"}, 32'(o_return_valid), 32'(vld));
    chk({tag, ".coin"},  32'(o_return_coin), 32'(rc));
    chk({tag, ".item"},  32'(o_output_item), 32'(oi));
    chk({tag, ".busy"},  32'(o_busy), 32'(busy));
  endtask

  // Drive inputs away from the edge, advance one edge, sample 1 time unit later.
  task automatic step(input logic [2:0] c, input logic [3:0] it, input logic tr, input logic rd);
    i_input_coin     = c;
    i_select_item    = it;
    i_trigger_return = tr;
    i_disp_ready     = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(3'b000, 4'b0000, 1'b0, 1'b1);
    reset_n = 1'b1;
  endtask

  initial begin
    // coin, item, trig, rdy | total, wait, valid, coin, item, busy
    vecs[0]  = '{3'b100, 4'b0000, 1'b0, 1'b1, 16'd1000, 32'd10, 1'b0, 3'b000, 4'b0000, 1'b0};
    vecs[1]  = '{3'b010, 4'b0000, 1'b0, 1'b1, 16'd1500, 32'd10, 1'b0, 3'b000, 4'b0000, 1'b0};
    vecs[2]  = '{3'b001, 4'b0000, 1'b0, 1'b1, 16'd1600, 32'd10, 1'b0, 3'b000, 4'b0000, 1'b0};
    vecs[3]  = '{3'b000, 4'b0000, 1'b1, 1'b1, 16'd1600, 32'd0,  1'b1, 3'b100, 4'b0000, 1'b1};
    vecs[4]  = '{3'b000, 4'b0000, 1'b0, 1'b1, 16'd600,  32'd0,  1'b1, 3'b010, 4'b0000, 1'b1};
    vecs[5]  = '{3'b000, 4'b0000, 1'b0, 1'b1, 16'd100,  32'd0,  1'b1, 3'b001, 4'b0000, 1'b1};
    vecs[6]  = '{3'b000, 4'b0000, 1'b0, 1'b1, 16'd0,    32'd0,  1'b0, 3'b000, 4'b0000, 1'b0};
    vecs[7]  = '{3'b011, 4'b0000, 1'b0, 1'b1, 16'd0,    32'd0,  1'b0, 3'b000, 4'b0000, 1'b0};
    vecs[8]  = '{3'b010, 4'b0000, 1'b0, 1'b1, 16'd500,  32'd10, 1'b0, 3'b000, 4'b0000, 1'b0};
    vecs[9]  = '{3'b000, 4'b0010, 1'b0, 1'b1, 16'd0,    32'd10, 1'b0, 3'b000, 4'b0010, 1'b0};
    vecs[10] = '{3'b000, 4'b0000, 1'b0, 1'b1, 16'd0,    32'd10, 1'b0, 3'b000, 4'b0000, 1'b0};
    vecs[11] = '{3'b100, 4'b0000, 1'b0, 1'b1, 16'd1000, 32'd10, 1'b0, 3'b000, 4'b0000, 1'b0};
    vecs[12] = '{3'b001, 4'b0001, 1'b0, 1'b1, 16'd700,  32'd10, 1'b0, 3'b000, 4'b0001, 1'b0};
    vecs[13] = '{3'b100, 4'b0000, 1'b1, 1'b0, 16'd700,  32'd0,  1'b1, 3'b010, 4'b0000, 1'b1};
    vecs[14] = '{3'b001, 4'b0000, 1'b0, 1'b0, 16'd700,  32'd0,  1'b1, 3'b010, 4'b0000, 1'b1};
    vecs[15] = '{3'b000, 4'b0000, 1'b0, 1'b1, 16'd200,  32'd0,  1'b1, 3'b001, 4'b0000, 1'b1};
    vecs[16] = '{3'b000, 4'b0000, 1'b0, 1'b1, 16'd100,  32'd0,  1'b1, 3'b001, 4'b0000, 1'b1};
    vecs[17] = '{3'b000, 4'b0000, 1'b0, 1'b1, 16'd0,    32'd0,  1'b0, 3'b000, 4'b0000, 1'b0};
    vecs[18] = '{3'b000, 4'b0000, 1'b1, 1'b1, 16'd0,    32'd0,  1'b0, 3'b000, 4'b0000, 1'b0};

    reset_n = 1'b0;
    step(3'b000, 4'b0000, 1'b0, 1'b0);
    step(3'b000, 4'b0000, 1'b0, 1'b0);
    check_outs("reset", 16'd0, 32'd0, 1'b0, 3'b000, 4'b0000, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].coin, vecs[i].item, vecs[i].trig, vecs[i].rdy);
      check_outs($sformatf("vec%0d", i), vecs[i].total, vecs[i].wt, vecs[i].vld,
                 vecs[i].rc, vecs[i].oi, vecs[i].busy);
    end

    // Timeout: 500 + 100, then countdown 10..0 and automatic payout.
    step(3'b010, 4'b0000, 1'b0, 1'b1);
    step(3'b001, 4'b0000, 1'b0, 1'b1);
    check_outs("tmo.load", 16'd600, 32'd10, 1'b0, 3'b000, 4'b0000, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(3'b000, 4'b0000, 1'b0, 1'b1);
      check_outs($sformatf("tmo.cnt%0d", k), 16'd600, 32'(10 - k), 1'b0, 3'b000, 4'b0000, 1'b0);
    end
    step(3'b000, 4'b0000, 1'b0, 1'b1);
    check_outs("tmo.ret", 16'd600, 32'd0, 1'b1, 3'b010, 4'b0000, 1'b1);
    step(3'b000, 4'b0000, 1'b0, 1'b1);
    check_outs("tmo.c2", 16'd100, 32'd0, 1'b1, 3'b001, 4'b0000, 1'b1);
    step(3'b000, 4'b0000, 1'b0, 1'b1);
    check_outs("tmo.idle", 16'd0, 32'd0, 1'b0, 3'b000, 4'b0000, 1'b0);

    // Insufficient funds, then exact purchase.
    for (int k = 0; k < 4; k++) step(3'b001, 4'b0000, 1'b0, 1'b1);
    check_outs("buy.bal", 16'd400, 32'd10, 1'b0, 3'b000, 4'b0000, 1'b0);
    step(3'b000, 4'b0000, 1'b0, 1'b1);
    step(3'b000, 4'b0000, 1'b0, 1'b1);
    check_outs("buy.dec", 16'd400, 32'd8, 1'b0, 3'b000, 4'b0000, 1'b0);
    step(3'b000, 4'b0010, 1'b0, 1'b1);
    check_outs("buy.short", 16'd400, 32'd7, 1'b0, 3'b000, 4'b0000, 1'b0);
    step(3'b000, 4'b0001, 1'b0, 1'b1);
    check_outs("buy.ok", 16'd0, 32'd10, 1'b0, 3'b000, 4'b0001, 1'b0);
    step(3'b000, 4'b0000, 1'b0, 1'b1);
    check_outs("buy.pulse", 16'd0, 32'd10, 1'b0, 3'b000, 4'b0000, 1'b0);

    // Dispenser stalls for three cycles: coin held stable.
    step(3'b100, 4'b0000, 1'b0, 1'b0);
    step(3'b010, 4'b0000, 1'b0, 1'b0);
    step(3'b000, 4'b0000, 1'b1, 1'b0);
    check_outs("stall.0", 16'd1500, 32'd0, 1'b1, 3'b100, 4'b0000, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      step(3'b000, 4'b0000, 1'b0, 1'b0);
      check_outs($sformatf("stall.%0d", k), 16'd1500, 32'd0, 1'b1, 3'b100, 4'b0000, 1'b1);
    end
    step(3'b000, 4'b0000, 1'b0, 1'b1);
    check_outs("stall.go", 16'd500, 32'd0, 1'b1, 3'b010, 4'b0000, 1'b1);
    step(3'b000, 4'b0000, 1'b0, 1'b1);
    check_outs("stall.idle", 16'd0, 32'd0, 1'b0, 3'b000, 4'b0000, 1'b0);

    // Same-cycle coin and purchase.
    step(3'b010, 4'b0000, 1'b0, 1'b1);
    step(3'b100, 4'b0100, 1'b0, 1'b1);
    check_outs("same.short", 16'd1500, 32'd10, 1'b0, 3'b000, 4'b0000, 1'b0);
    do_reset();
    check_outs("same.rst", 16'd0, 32'd0, 1'b0, 3'b000, 4'b0000, 1'b0);
    step(3'b100, 4'b0000, 1'b0, 1'b1);
    step(3'b100, 4'b0100, 1'b0, 1'b1);
    check_outs("same.buy", 16'd1000, 32'd10, 1'b0, 3'b000, 4'b0100, 1'b0);
    do_reset();

    // Reset during payout, then a normal coin.
    step(3'b100, 4'b0000, 1'b0, 1'b0);
    step(3'b010, 4'b0000, 1'b0, 1'b0);
    step(3'b000, 4'b0000, 1'b1, 1'b0);
    step(3'b000, 4'b0000, 1'b0, 1'b1);
    check_outs("mid.xfer", 16'd500, 32'd0, 1'b1, 3'b010, 4'b0000, 1'b1);
    reset_n = 1'b0;
    step(3'b000, 4'b0000, 1'b0, 1'b1);
    check_outs("mid.rst", 16'd0, 32'd0, 1'b0, 3'b000, 4'b0000, 1'b0);
    reset_n = 1'b1;
    step(3'b001, 4'b0000, 1'b0, 1'b1);
    check_outs("mid.coin", 16'd100, 32'd10, 1'b0, 3'b000, 4'b0000, 1'b0);
    do_reset();

    // Balance overflow boundary.
    for (int k = 0; k < 65; k++) step(3'b100, 4'b0000, 1'b0, 1'b0);
    step(3'b010, 4'b0000, 1'b0, 1'b0);
    check_outs("ovf.max", 16'd65500, 32'd10, 1'b0, 3'b000, 4'b0000, 1'b0);
    step(3'b000, 4'b0000, 1'b0, 1'b0);
    step(3'b001, 4'b0000, 1'b0, 1'b0);
    check_outs("ovf.rej100", 16'd65500, 32'd8, 1'b0, 3'b000, 4'b0000, 1'b0);
    step(3'b100, 4'b0000, 1'b0, 1'b0);
    check_outs("ovf.rej1000", 16'd65500, 32'd7, 1'b0, 3'b000, 4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
